// File: rtl/hdec_scan.sv
// hdec_scan: registered N-to-2^N one-hot decoder with scan sequencer (HDEC_BLANK_EN adds a blank cycle between lines)
module hdec_scan #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [N-1:0]     w_i,
  output logic [(1<<N)-1:0] y_o,
  output logic [N-1:0]     idx_o,
  output logic             wrap_o
);
  localparam int M  = 1 << N;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [M-1:0]  ONE   = M'(1);
`ifdef HDEC_BLANK_EN
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
`endif
  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d, adv;
  logic [DW-1:0]  dcnt_q, dcnt_d;
  logic [M-1:0]   y_q, y_d;
  logic           wrap_q, wrap_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = '0;
    y_d     = '0;
    wrap_d  = 1'b0;
    adv     = idx_q + N'(1);
    if (!en_i) begin
      state_d = IDLE;
    end else if (!mode_i) begin
      state_d = DIRECT;
      idx_d   = load_i ? w_i : idx_q;
      y_d     = ONE << idx_d;
    end else if (load_i) begin
      state_d = SCAN;
      idx_d   = w_i;
      y_d     = ONE << w_i;
    end else if (state_q != SCAN) begin
      // entry (and return from blank) restarts a full dwell on the current line
      state_d = SCAN;
      y_d     = ONE << idx_q;
    end else if (dcnt_q != DLAST) begin
      dcnt_d = dcnt_q + DW'(1);
      y_d    = y_q;
    end else begin
      idx_d  = adv;
      wrap_d = (adv == '0);
`ifdef HDEC_BLANK_EN
      state_d = BLANK;
`else
      y_d = ONE << adv;
`endif
    end
  end
  assign y_o    = y_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_hdec_scan.sv
// tb_hdec_scan: directed self-checking bench for hdec_scan (N=3, DWELL=4, blanking off)
module tb_hdec_scan;
  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [2:0] w;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;
  int         passed = 0;
  int         total = 0;

  hdec_scan #(.N(3), .DWELL(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .load_i(load),
    .w_i(w), .y_o(y), .idx_o(idx), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; mode = 0; load = 0; w = 0;
    step();
    rst = 0;
    total++;
    if (y !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0)
      $display("FAIL reset y=%h idx=%0d wrap=%b want y=00 idx=0 wrap=0", y, idx, wrap);
    else passed++;
  endtask

  task automatic test_direct();
    en = 1; mode = 0; load = 1; w = 5;
    step();
    total++;
    if (y !== 8'h20 || idx !== 3'd5 || wrap !== 1'b0)
      $display("FAIL direct_load y=%h idx=%0d wrap=%b want y=20 idx=5 wrap=0", y, idx, wrap);
    else passed++;
    load = 0; w = 2;
    step();
    total++;
    if (y !== 8'h20 || idx !== 3'd5)
      $display("FAIL direct_hold y=%h idx=%0d want y=20 idx=5", y, idx);
    else passed++;
  endtask

  task automatic test_full_scan();
    logic [7:0] ey;
    mode = 0; load = 1; w = 0;
    step();
    load = 0; mode = 1;
    for (int k = 0; k <= 32; k++) begin
      step();
      ey = 8'h01 << ((k / 4) % 8);
      total++;
      if (y !== ey || wrap !== (k == 32))
        $display("FAIL full_scan k=%0d y=%h wrap=%b want y=%h wrap=%b", k, y, wrap, ey, k == 32);
      else passed++;
    end
  endtask

  task automatic test_load_mid_scan();
    mode = 0; load = 1; w = 3;
    step();
    load = 0; mode = 1;
    step();
    step();
    step();
    load = 1; w = 6;
    step();
    load = 0;
    total++;
    if (y !== 8'h40 || idx !== 3'd6 || wrap !== 1'b0)
      $display("FAIL mid_load y=%h idx=%0d wrap=%b want y=40 idx=6 wrap=0", y, idx, wrap);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (y !== (i < 4 ? 8'h40 : 8'h80) || wrap !== 1'b0)
        $display("FAIL mid_load_dwell i=%0d y=%h wrap=%b want y=%h wrap=0", i, y, wrap, i < 4 ? 8'h40 : 8'h80);
      else passed++;
    end
  endtask

  task automatic test_en_drop();
    mode = 0; load = 1; w = 4;
    step();
    load = 0; mode = 1;
    step();
    step();
    en = 0; load = 1; w = 1;
    step();
    load = 0;
    total++;
    if (y !== 8'h00 || idx !== 3'd4 || wrap !== 1'b0)
      $display("FAIL en_drop y=%h idx=%0d wrap=%b want y=00 idx=4 wrap=0", y, idx, wrap);
    else passed++;
    en = 1; mode = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (y !== (i < 4 ? 8'h10 : 8'h20))
        $display("FAIL en_resume i=%0d y=%h want %h", i, y, i < 4 ? 8'h10 : 8'h20);
      else passed++;
    end
    mode = 0;
    step();
    total++;
    if (y !== 8'h20 || idx !== 3'd5)
      $display("FAIL scan_to_direct y=%h idx=%0d want y=20 idx=5", y, idx);
    else passed++;
  endtask

  task automatic test_reset_mid();
    mode = 0; load = 1; w = 7;
    step();
    load = 0; mode = 1;
    step();
    step();
    rst = 1; load = 1; w = 3;
    step();
    rst = 0; load = 0; mode = 0;
    total++;
    if (y !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0)
      $display("FAIL reset_mid y=%h idx=%0d wrap=%b want y=00 idx=0 wrap=0", y, idx, wrap);
    else passed++;
    step();
    total++;
    if (y !== 8'h01 || idx !== 3'd0)
      $display("FAIL after_reset y=%h idx=%0d want y=01 idx=0", y, idx);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_full_scan();
    test_load_mid_scan();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hdec_scan.md
# hdec_scan

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. In direct mode it latches a select code and drives the matching one-hot line. In scan mode it steps through all 2^N lines on its own, with a programmable dwell per line. It replaces fixed combinational decoders wherever a clocked, glitch-free select bus is needed, e.g. digit or row strobes for multiplexed displays and keypads.

## Interface
Parameters:
- N, 3, select width; output width is 2^N; N >= 1
- DWELL, 4, clock cycles each line stays active in scan mode; DWELL >= 1; dwell counter width is $clog2(DWELL), minimum 1

Ports:
- Clock  input  1  rising-edge clock; the only clock
- Reset  input  1  synchronous, active-high reset
- En  input  1  block enable; 0 forces all outputs inactive
- Mode  input  1  0 = direct, 1 = scan
- Load  input  1  capture w into the index register (both modes)
- w  input  N  select code
- y  output  2^N  registered one-hot select, all-zero when inactive
- Idx  output  N  current index register
- Wrap  output  1  one-cycle pulse when the scan rolls over from 2^N-1 to 0

## Operation
- Internal state is one of IDLE, DIRECT, SCAN, plus BLANK when the macro is enabled. There is also a dwell counter Dcnt.
- Reset (Reset=1 at an edge) has priority over every other input. Afterwards: state IDLE, y=0, Idx=0, Dcnt=0, Wrap=0. Reset asserted in any state, including mid-dwell, gives the same result.
- En=0 at an edge: state IDLE, y=0, Dcnt=0, Wrap=0, Idx held. Load is ignored.
- En=1, Mode=0 (DIRECT):
  - Load=1 sets Idx=w.
  - y=one-hot(Idx), using the new Idx when Load=1 in the same cycle.
  - Dcnt is held at 0. Wrap=0.
- En=1, Mode=1 (SCAN):
  - Load=1 sets Idx=w, Dcnt=0 and y=one-hot(w); Wrap=0. Load takes priority over advance.
  - Otherwise, if Dcnt < DWELL-1: Dcnt increments and y is unchanged.
  - Otherwise (Dcnt = DWELL-1), advance: Idx=(Idx+1) mod 2^N, Dcnt=0, y=one-hot(new Idx).
  - Wrap=1 for exactly that cycle when the new Idx is 0.
- Entering SCAN from IDLE or DIRECT: the first edge sets y=one-hot(Idx) and Dcnt=0, so the current line gets a full dwell.
- Leaving SCAN for DIRECT: Idx is held and y stays on the same line.
- y is never multi-hot. It is either exactly one-hot or all-zero.

## Timing
- All outputs are registered and change only on the rising Clock edge.
- Latency is 1 cycle from a sampled En/Mode/Load/w to y, Idx and Wrap.
- From IDLE, the edge that samples En=1 makes y active after that same edge.
- Scan period, macro off: each line is active for exactly DWELL cycles; a full scan takes DWELL*2^N cycles.
- DWELL=1: the active line advances every cycle, and Wrap pulses every 2^N cycles.

## Configuration
- HDEC_BLANK_EN defined: break-before-make blanking in scan mode.
  - An advance first enters BLANK for one cycle: y=0, Idx already updated, Dcnt=0, Wrap asserted here if the new Idx is 0.
  - On the next edge, y=one-hot(Idx) and the dwell starts.
  - Each line occupies DWELL+1 cycles (DWELL active plus 1 blank).
  - Load during BLANK returns straight to SCAN with y=one-hot(w).
  - En=0 during BLANK goes to IDLE.
- HDEC_BLANK_EN undefined: there is no BLANK state, advances go directly from line to line, and timing is as given above.

## Test plan
- Reset then direct load: Reset 1 cycle, En=1, Mode=0, Load=1, w=5 -> one cycle later y=8'b0010_0000, Idx=5, Wrap=0. Load=0, w=2 -> y unchanged.
- Full scan, N=3, DWELL=4, macro off: from Idx=0 -> y steps 01, 02, 04 … 80, each for exactly 4 cycles. Wrap pulses once, 32 cycles after scan start, aligned with y returning to 8'h01.
- Load in mid-scan: with Dcnt=2 on Idx=3, Load=1, w=6 -> y=8'h40, Idx=6. The next advance comes 4 cycles later. No Wrap.
- En drop and resume: En=0 mid-dwell on Idx=4 -> next cycle y=0, Idx=4. Re-assert En with Mode=1 -> y=8'h10 for a full 4 cycles.
- Reset mid-operation: Reset=1 during a scan at Idx=7 -> y=0, Idx=0, Wrap=0 on the next edge, even if Load=1 in the same cycle.
- HDEC_BLANK_EN with DWELL=1: y alternates line/0 (01, 00, 02, 00 …). Wrap pulses in the blank cycle after 8'h80, and the scan period is 16 cycles.
